fetch_unit: RTL

Instruction fetch stage of the RV32 core. It is the consumer of the branch unit's next-PC result.
- Holds the architectural PC.
- Issues word requests to instruction memory over a valid/ready request channel with an unconditional response channel.
- Buffers returned instructions in a small FIFO toward decode.
- Accepts redirects (taken branch/jump target), flushing all in-flight and buffered work.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : rv32_pkg                                                  |
// | Brief    : Shared RV32 fetch constants, FSM encoding, buffer entry.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package rv32_pkg;

   localparam int          XLEN    = 32;
   localparam int          INST_W  = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +----------------------------------------------------------------------+
// | Module   : fetch_fifo                                                |
// | Brief    : Instruction buffer with push/pop/flush and head output.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
   import rv32_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  fetch_entry_t               push_entry,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(BUF_DEPTH):0] count,
   output fetch_entry_t               head
);

   localparam int                  C_PTR_W = $clog2(BUF_DEPTH);
   localparam int                  C_CNT_W = C_PTR_W + 1;
   localparam logic [C_CNT_W-1:0]  c_full  = C_CNT_W'(BUF_DEPTH);
   localparam logic [C_PTR_W-1:0]  c_ptr_one = C_PTR_W'(1);

   fetch_entry_t         r_mem [BUF_DEPTH];
   logic [C_PTR_W-1:0]   r_wptr;
   logic [C_PTR_W-1:0]   r_rptr;
   logic [C_CNT_W-1:0]   r_count;
   logic                 w_push;
   logic                 w_pop;

   // Flush beats a simultaneous push; the pushed entry is simply lost.
   assign w_push = push & ~flush;
   assign w_pop  = pop & ~flush & (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         assert (!(push && (r_count == c_full)));
         if (w_push) begin
            r_mem[r_wptr] <= push_entry;
            r_wptr        <= r_wptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_ptr_one;
         end
         r_count <= r_count + {{C_PTR_W{1'b0}}, w_push} - {{C_PTR_W{1'b0}}, w_pop};
      end
   end

   assign count = r_count;
   assign head  = r_mem[r_rptr];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------+
// | Module   : fetch_unit                                                |
// | Brief    : RV32 fetch stage: PC, imem request FSM, decode buffer.    |
// |            Option FETCH_MISALIGN_CHECK_EN halts on misaligned target.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_unit
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        misalign_err
);

   localparam int                 C_CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam logic [C_CNT_W-1:0] c_full  = C_CNT_W'(BUF_DEPTH);

   fetch_state_t        r_state;
   fetch_state_t        w_next_state;
   logic [XLEN-1:0]     r_pc;
   logic [XLEN-1:0]     r_req_pc;
   logic [XLEN-1:0]     w_redirect_pc;
   logic                w_req_valid;
   logic                w_hs;
   logic                w_push;
   logic                w_halt;
   logic [C_CNT_W-1:0]  w_count;
   fetch_entry_t        w_head;

   assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
   logic r_misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         r_misalign <= 1'b1;
      end
   end

   assign w_halt       = r_misalign;
   assign misalign_err = r_misalign;
`else
   logic w_unused_lsb;

   assign w_unused_lsb = ^redirect_pc[1:0];
   assign w_halt       = 1'b0;
   assign misalign_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= REQ;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A redirect that races an accepted or pending request leaves a stale response owed.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         REQ: begin
            if (redirect_valid) begin
               w_next_state = w_hs ? DROP : REQ;
            end else if (w_hs) begin
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               w_next_state = REQ;
            end else if (redirect_valid) begin
               w_next_state = DROP;
            end
         end
         DROP: begin
            if (imem_rsp_valid) begin
               w_next_state = REQ;
            end
         end
         default: w_next_state = REQ;
      endcase
   end

   always_comb begin
      w_req_valid = rst_n && (r_state == REQ) && (w_count < c_full) && !w_halt;
      w_hs        = w_req_valid && imem_req_ready;
      w_push      = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_req_pc <= RESET_PC;
      end else begin
         if (redirect_valid) begin
            r_pc <= w_redirect_pc;
         end else if (w_push) begin
            r_pc <= r_pc + PC_STEP;
         end
         if (w_hs) begin
            r_req_pc <= r_pc;
         end
      end
   end

   fetch_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (w_push),
      .push_entry ('{pc: r_req_pc, inst: imem_rdata}),
      .pop        (inst_ready),
      .flush      (redirect_valid),
      .count      (w_count),
      .head       (w_head)
   );

   assign imem_req_valid = w_req_valid;
   assign imem_addr      = r_pc;
   assign inst_valid     = (w_count != '0);
   assign inst           = w_head.inst;
   assign inst_pc        = w_head.pc;

endmodule

`default_nettype wire
